// File: rtl/rt_rst_ctrl_pkg.sv
// Shared types and helpers for the RT-SS reset and clock-enable sequencer.
package rt_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    CLK_EN    = 3'd2,
    REL_SYS   = 3'd3,
    RUN       = 3'd4,
    ASSERT    = 3'd5
  } rst_state_e;

  typedef enum logic [1:0] {
    POR       = 2'd0,
    LOCK_LOSS = 2'd1,
    EXT       = 2'd2,
    SW        = 2'd3
  } rst_cause_e;

  // Width needed to hold the largest terminal count of any phase.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rt_rst_ctrl_sync.sv
// N-stage synchroniser for asynchronous level inputs, with a selectable reset value.
module rt_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  // Shift the raw input in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  // Chain of flops; reset forces the safe (asserted) value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/rt_rst_ctrl.sv
// Reset and clock-enable sequencer: qualifies lock and external reset, then
// releases clock enable, system reset and core reset in stages.
module rt_rst_ctrl
  import rt_rst_ctrl_pkg::*;
#(
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned LockStableCycles = 1024,
  parameter int unsigned StageDelay       = 16,
  parameter int unsigned MinAssertCycles  = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  input  logic       sw_rst_req_i,
  output logic       clk_en_o,
  output logic       rst_sys_no,
  output logic       rst_core_no,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned CntW = cnt_width(LockStableCycles, StageDelay, MinAssertCycles);
  localparam logic [CntW-1:0] LockLast   = CntW'(LockStableCycles - 1);
  localparam logic [CntW-1:0] StageLast  = CntW'(StageDelay - 1);
  localparam logic [CntW-1:0] AssertLast = CntW'(MinAssertCycles - 1);

  logic lock_s;
  logic ext_s;
  logic fault;

  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rst_cause_e      cause_q, cause_d;
  rst_cause_e      fault_cause;
  logic            clk_en_q, clk_en_d;
  logic            rst_sys_q, rst_sys_d;
  logic            rst_core_q, rst_core_d;
  logic            done_q, done_d;

  rt_sync #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_lock (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_locked_i),
    .q_o    (lock_s)
  );

  rt_sync #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_ext (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ext_rst_ni),
    .q_o    (ext_s)
  );

  assign fault       = !lock_s || !ext_s;
  assign fault_cause = !lock_s ? LOCK_LOSS : EXT;

  // Sequencing state machine: next state, phase counter and latched cause.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s && ext_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (fault) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          state_d = CLK_EN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLK_EN, REL_SYS: begin
        if (fault) begin
          state_d = ASSERT;
          cause_d = fault_cause;
          cnt_d   = '0;
        end else if (cnt_q == StageLast) begin
          state_d = (state_q == CLK_EN) ? REL_SYS : RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (fault) begin
          state_d = ASSERT;
          cause_d = fault_cause;
        end else if (sw_rst_req_i) begin
          state_d = ASSERT;
          cause_d = SW;
        end
      end
      ASSERT: begin
        if (cnt_q == AssertLast) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs change on the entering edge.
  always_comb begin
    clk_en_d   = (state_d == CLK_EN) || (state_d == REL_SYS) ||
                 (state_d == RUN)    || (state_d == ASSERT);
    rst_sys_d  = (state_d == REL_SYS) || (state_d == RUN);
    rst_core_d = (state_d == RUN);
    done_d     = (state_d == RUN);
  end

  // State, counter, cause and registered outputs; power-on holds everything off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      cause_q    <= POR;
      clk_en_q   <= 1'b0;
      rst_sys_q  <= 1'b0;
      rst_core_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      clk_en_q   <= clk_en_d;
      rst_sys_q  <= rst_sys_d;
      rst_core_q <= rst_core_d;
      done_q     <= done_d;
    end
  end

  assign clk_en_o    = clk_en_q;
  assign rst_sys_no  = rst_sys_q;
  assign rst_core_no = rst_core_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rt_rst_ctrl.sv
// Directed bench for rt_rst_ctrl with small sequencing parameters.
module tb_rt_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       ext_n;
  logic       sw_req;
  logic       clk_en;
  logic       rst_sys_n;
  logic       rst_core_n;
  logic       done;
  logic [1:0] cause;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  // Observed vector: {clk_en, rst_sys_n, rst_core_n, done, cause[1:0]}.
  assign obs = {clk_en, rst_sys_n, rst_core_n, done, cause};

  rt_rst_ctrl #(
    .SyncStages       (2),
    .LockStableCycles (8),
    .StageDelay       (4),
    .MinAssertCycles  (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pll_locked_i (lock),
    .ext_rst_ni   (ext_n),
    .sw_rst_req_i (sw_req),
    .clk_en_o     (clk_en),
    .rst_sys_no   (rst_sys_n),
    .rst_core_no  (rst_core_n),
    .rst_done_o   (done),
    .rst_cause_o  (cause)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold power-on reset with lock and ext already good, then release just after an edge.
  task automatic apply_reset();
    rst_n  = 1'b0;
    lock   = 1'b1;
    ext_n  = 1'b1;
    sw_req = 1'b0;
    tick(2);
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_state got %b expected %b", obs, 6'b000000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_power_on();
    apply_reset();
    tick(10);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("[TB] FAIL por_e10 got %b expected %b", obs, 6'b000000); end
    tick(1);
    checks++;
    if (obs !== 6'b100000) begin errors++; $display("[TB] FAIL por_e11_clk_en got %b expected %b", obs, 6'b100000); end
    tick(3);
    checks++;
    if (obs !== 6'b100000) begin errors++; $display("[TB] FAIL por_e14 got %b expected %b", obs, 6'b100000); end
    tick(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("[TB] FAIL por_e15_sys got %b expected %b", obs, 6'b110000); end
    tick(3);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("[TB] FAIL por_e18 got %b expected %b", obs, 6'b110000); end
    tick(1);
    checks++;
    if (obs !== 6'b111100) begin errors++; $display("[TB] FAIL por_e19_run got %b expected %b", obs, 6'b111100); end
  endtask

  task automatic test_lock_loss();
    lock = 1'b0;
    tick(2);
    checks++;
    if (obs !== 6'b111100) begin errors++; $display("[TB] FAIL lockloss_still_run got %b expected %b", obs, 6'b111100); end
    tick(1);
    checks++;
    if (obs !== 6'b100001) begin errors++; $display("[TB] FAIL lockloss_assert got %b expected %b", obs, 6'b100001); end
    tick(3);
    checks++;
    if (obs !== 6'b100001) begin errors++; $display("[TB] FAIL lockloss_assert_end got %b expected %b", obs, 6'b100001); end
    tick(1);
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("[TB] FAIL lockloss_clk_off got %b expected %b", obs, 6'b000001); end
    lock = 1'b1;
    tick(18);
    checks++;
    if (obs !== 6'b110001) begin errors++; $display("[TB] FAIL lockloss_rel_sys got %b expected %b", obs, 6'b110001); end
    tick(1);
    checks++;
    if (obs !== 6'b111101) begin errors++; $display("[TB] FAIL lockloss_rerun got %b expected %b", obs, 6'b111101); end
  endtask

  task automatic test_sw_reset();
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    checks++;
    if (obs !== 6'b100011) begin errors++; $display("[TB] FAIL sw_assert got %b expected %b", obs, 6'b100011); end
    tick(3);
    checks++;
    if (obs !== 6'b100011) begin errors++; $display("[TB] FAIL sw_assert_end got %b expected %b", obs, 6'b100011); end
    tick(1);
    checks++;
    if (obs !== 6'b000011) begin errors++; $display("[TB] FAIL sw_clk_off got %b expected %b", obs, 6'b000011); end
    tick(8);
    checks++;
    if (obs !== 6'b000011) begin errors++; $display("[TB] FAIL sw_stabilize got %b expected %b", obs, 6'b000011); end
    tick(1);
    checks++;
    if (obs !== 6'b100011) begin errors++; $display("[TB] FAIL sw_clk_en got %b expected %b", obs, 6'b100011); end
    tick(7);
    checks++;
    if (obs !== 6'b110011) begin errors++; $display("[TB] FAIL sw_rel_sys got %b expected %b", obs, 6'b110011); end
    tick(1);
    checks++;
    if (obs !== 6'b111111) begin errors++; $display("[TB] FAIL sw_rerun got %b expected %b", obs, 6'b111111); end
  endtask

  task automatic test_simultaneous();
    lock  = 1'b0;
    ext_n = 1'b0;
    tick(2);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    checks++;
    if (obs !== 6'b100001) begin errors++; $display("[TB] FAIL simul_cause got %b expected %b", obs, 6'b100001); end
    tick(1);
    lock  = 1'b1;
    ext_n = 1'b1;
    tick(2);
    checks++;
    if (obs !== 6'b100001) begin errors++; $display("[TB] FAIL simul_assert_end got %b expected %b", obs, 6'b100001); end
    tick(1);
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("[TB] FAIL simul_clk_off got %b expected %b", obs, 6'b000001); end
    tick(2);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("[TB] FAIL simul_sw_in_stab got %b expected %b", obs, 6'b000001); end
    tick(5);
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("[TB] FAIL simul_pre_clk_en got %b expected %b", obs, 6'b000001); end
    tick(1);
    checks++;
    if (obs !== 6'b100001) begin errors++; $display("[TB] FAIL simul_clk_en got %b expected %b", obs, 6'b100001); end
    tick(8);
    checks++;
    if (obs !== 6'b111101) begin errors++; $display("[TB] FAIL simul_rerun got %b expected %b", obs, 6'b111101); end
  endtask

  task automatic test_ext_reset();
    ext_n = 1'b0;
    tick(3);
    checks++;
    if (obs !== 6'b100010) begin errors++; $display("[TB] FAIL ext_assert got %b expected %b", obs, 6'b100010); end
    ext_n = 1'b1;
    tick(4);
    checks++;
    if (obs !== 6'b000010) begin errors++; $display("[TB] FAIL ext_clk_off got %b expected %b", obs, 6'b000010); end
    tick(9);
    checks++;
    if (obs !== 6'b100010) begin errors++; $display("[TB] FAIL ext_clk_en got %b expected %b", obs, 6'b100010); end
    tick(4);
    checks++;
    if (obs !== 6'b110010) begin errors++; $display("[TB] FAIL ext_rel_sys got %b expected %b", obs, 6'b110010); end
    tick(1);
    checks++;
    if (obs !== 6'b110010) begin errors++; $display("[TB] FAIL ext_mid_rel_sys got %b expected %b", obs, 6'b110010); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("[TB] FAIL async_reset got %b expected %b", obs, 6'b000000); end
    tick(1);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("[TB] FAIL async_reset_held got %b expected %b", obs, 6'b000000); end
  endtask

  task automatic test_lock_glitch();
    apply_reset();
    tick(5);
    lock = 1'b0;
    tick(3);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("[TB] FAIL glitch_e8 got %b expected %b", obs, 6'b000000); end
    lock = 1'b1;
    tick(3);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("[TB] FAIL glitch_no_early_clk_en got %b expected %b", obs, 6'b000000); end
    tick(7);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("[TB] FAIL glitch_e18 got %b expected %b", obs, 6'b000000); end
    tick(1);
    checks++;
    if (obs !== 6'b100000) begin errors++; $display("[TB] FAIL glitch_clk_en got %b expected %b", obs, 6'b100000); end
    tick(7);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("[TB] FAIL glitch_rel_sys got %b expected %b", obs, 6'b110000); end
    tick(1);
    checks++;
    if (obs !== 6'b111100) begin errors++; $display("[TB] FAIL glitch_run got %b expected %b", obs, 6'b111100); end
  endtask

  // Scenario sequence; each task starts where the previous one left the DUT.
  initial begin
    rst_n  = 1'b0;
    lock   = 1'b0;
    ext_n  = 1'b0;
    sw_req = 1'b0;
    test_power_on();
    test_lock_loss();
    test_sw_reset();
    test_simultaneous();
    test_ext_reset();
    test_async_reset();
    test_lock_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog in case the scenario sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
